// File: rtl/mem_dpi_pkg.sv
// Lane width, byte-masked lane merge and the 64-bit backing-memory accessors.
// Backing store is a sparse associative array owned by this package; never cleared by reset.
package mem_dpi_pkg;

  localparam int LANE_W     = 64;
  localparam int LANE_BYTES = LANE_W / 8;

  longint unsigned backing [longint unsigned];

  function automatic longint unsigned mem_read_helper(
    input int unsigned space, input longint unsigned addr);
    longint unsigned key;
    key = addr ^ {space, 32'h0};
    if (backing.exists(key)) return backing[key];
    return 64'd0;
  endfunction

  function automatic void mem_write_helper(
    input int unsigned space, input longint unsigned addr, input longint unsigned data);
    backing[addr ^ {space, 32'h0}] = data;
  endfunction

  function automatic logic [LANE_W-1:0] lane_merge(
    input logic [LANE_W-1:0]     old,
    input logic [LANE_W-1:0]     data,
    input logic [LANE_BYTES-1:0] mask8);
    logic [LANE_W-1:0] m;
    m = '0;
    for (int b = 0; b < LANE_BYTES; b++) m[8*b +: 8] = {8{mask8[b]}};
    return (old & ~m) | (data & m);
  endfunction

endpackage

// File: rtl/mem_rsp_fifo.sv
// In-order response FIFO; head is registered storage, visible the edge after push (no bypass).
// Head holds stable until popped; the writer must never push while full.
module mem_rsp_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_vld,
  input  logic [WIDTH-1:0] wr_dat,
  output logic             rd_vld,
  input  logic             rd_rdy,
  output logic [WIDTH-1:0] rd_dat
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count;
  logic             full, push, pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign full   = (count == CNT_W'(DEPTH));
  assign rd_vld = (count != '0);
  assign push   = wr_vld && !full;
  assign pop    = rd_vld && rd_rdy;
  assign rd_dat = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_dat;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Upstream credit accounting makes a push into a full FIFO impossible.
  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n) wr_vld |-> !full);

endmodule

// File: rtl/mem_dpi_port.sv
// Cycle-accurate memory agent: byte-masked RMW writes and lane-split reads against the backing store.
// Response LAT edges after accept (in order, after older ones drain); credit-limited to RSP_DEPTH outstanding.
module mem_dpi_port #(
  parameter int ADDR_W    = 64,
  parameter int DATA_W    = 256,
  parameter int ID_W      = 4,
  parameter int LAT       = 4,
  parameter int RSP_DEPTH = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_write,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [ID_W-1:0]     req_id,
  input  logic [DATA_W-1:0]   req_wdata,
  input  logic [DATA_W/8-1:0] req_wmask,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [ID_W-1:0]     rsp_id,
  output logic                rsp_write,
  output logic [DATA_W-1:0]   rsp_rdata
);

  import mem_dpi_pkg::*;

  localparam int LANES = DATA_W / LANE_W;
  localparam int OFF_W = $clog2(DATA_W / 8);
  localparam int CRD_W = $clog2(RSP_DEPTH + 1);

  typedef struct packed {
    logic [ID_W-1:0]   id;
    logic              write;
    logic [DATA_W-1:0] rdata;
  } mem_rsp_t;

  localparam int RSP_W = $bits(mem_rsp_t);

  logic [CRD_W-1:0]  credit, credit_nxt;
  logic              ready_q;
  logic              accept, rsp_hs;
  logic [ADDR_W-1:0] base;
  logic              addr_unused;
  logic [LAT-1:0]    pipe_vld;
  mem_rsp_t          pipe_dat [LAT];
  mem_rsp_t          head, rsp_out;
  logic              fifo_vld;

  assign req_ready   = ready_q;
  assign accept      = req_valid && ready_q;
  assign rsp_hs      = rsp_valid && rsp_ready;
  assign base        = {req_addr[ADDR_W-1:OFF_W], OFF_W'(0)};
  assign addr_unused = ^req_addr[OFF_W-1:0];

  always_comb begin
    credit_nxt = credit;
    if (accept && !rsp_hs)      credit_nxt = credit - CRD_W'(1);
    else if (!accept && rsp_hs) credit_nxt = credit + CRD_W'(1);
  end

  // req_ready is registered from the next credit value so it never depends on req_valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      credit  <= CRD_W'(RSP_DEPTH);
      ready_q <= 1'b0;
    end else begin
      credit  <= credit_nxt;
      ready_q <= (credit_nxt != '0);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pipe_vld <= '0;
    end else begin
      pipe_vld[0] <= accept;
      for (int i = 1; i < LAT; i++) pipe_vld[i] <= pipe_vld[i-1];
    end
  end

  // Memory side effects happen on the accept edge; read data is frozen into the pipeline there.
  always_ff @(posedge clk) begin
    if (accept) begin
      pipe_dat[0].id    <= req_id;
      pipe_dat[0].write <= req_write;
      pipe_dat[0].rdata <= '0;
      for (int k = 0; k < LANES; k++) begin
        if (req_write) begin
          if (req_wmask[k*LANE_BYTES +: LANE_BYTES] != '0)
            mem_write_helper(1, 64'(base) + 64'(k * LANE_BYTES),
                             lane_merge(mem_read_helper(1, 64'(base) + 64'(k * LANE_BYTES)),
                                        req_wdata[k*LANE_W +: LANE_W],
                                        req_wmask[k*LANE_BYTES +: LANE_BYTES]));
        end else begin
          pipe_dat[0].rdata[k*LANE_W +: LANE_W] <=
            mem_read_helper(1, 64'(base) + 64'(k * LANE_BYTES));
        end
      end
    end
    for (int i = 1; i < LAT; i++) pipe_dat[i] <= pipe_dat[i-1];
  end

  mem_rsp_fifo #(
    .WIDTH (RSP_W),
    .DEPTH (RSP_DEPTH)
  ) u_rsp_fifo (
    .clk    (clk),
    .rst_n  (rst_n),
    .wr_vld (pipe_vld[LAT-1]),
    .wr_dat (pipe_dat[LAT-1]),
    .rd_vld (fifo_vld),
    .rd_rdy (rsp_ready),
    .rd_dat (head)
  );

  // FIFO storage is not reset, so fields read as zero whenever no response is presented.
  assign rsp_valid = fifo_vld;
  assign rsp_out   = fifo_vld ? head : '0;
  assign rsp_id    = rsp_out.id;
  assign rsp_write = rsp_out.write;
  assign rsp_rdata = rsp_out.rdata;

  a_credit_range: assert property (@(posedge clk) disable iff (!rst_n)
                                   credit <= CRD_W'(RSP_DEPTH));

endmodule

// File: tb/tb_mem_dpi_port.sv
// Directed bench for mem_dpi_port: two instances (RSP_DEPTH 4 and 8) sharing one backing store.
`timescale 1ns/1ps
module tb_mem_dpi_port;

  localparam logic [255:0] WD_FIRST = {64'h3333, 64'h2222, 64'h1111, 64'hDEA};
  localparam logic [255:0] WD_PRE   = {64'h3, 64'h2, 64'h5555, 64'h1111_2222_3333_4444};
  localparam logic [255:0] WD_PART  = {64'hFFFF_FFFF_FFFF_FFFF, 64'hEEEE_EEEE_EEEE_EEEE,
                                       64'h9999_9999_9999_9999, 64'hAAAA_BBBB_CCCC_DDDD};
  localparam logic [255:0] EXP_80   = {64'h3, 64'h2, 64'h5599, 64'h1111_2222_CCCC_DDDD};
  localparam logic [255:0] WD_ALIGN = {64'hA3A3, 64'hA2A2, 64'hA1A1, 64'hA0A0};

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail = 0;

  logic         req_valid, req_ready, req_write, rsp_valid, rsp_ready, rsp_write;
  logic [63:0]  req_addr;
  logic [3:0]   req_id, rsp_id;
  logic [255:0] req_wdata, rsp_rdata;
  logic [31:0]  req_wmask;

  logic         b_req_valid, b_req_ready, b_req_write, b_rsp_valid, b_rsp_ready, b_rsp_write;
  logic [63:0]  b_req_addr;
  logic [3:0]   b_req_id, b_rsp_id;
  logic [255:0] b_req_wdata, b_rsp_rdata;
  logic [31:0]  b_req_wmask;

  mem_dpi_port #(.ADDR_W(64), .DATA_W(256), .ID_W(4), .LAT(4), .RSP_DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write), .req_addr(req_addr),
    .req_id(req_id), .req_wdata(req_wdata), .req_wmask(req_wmask),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_write(rsp_write),
    .rsp_rdata(rsp_rdata)
  );

  mem_dpi_port #(.ADDR_W(64), .DATA_W(256), .ID_W(4), .LAT(4), .RSP_DEPTH(8)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .req_valid(b_req_valid), .req_ready(b_req_ready), .req_write(b_req_write), .req_addr(b_req_addr),
    .req_id(b_req_id), .req_wdata(b_req_wdata), .req_wmask(b_req_wmask),
    .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready), .rsp_id(b_rsp_id), .rsp_write(b_rsp_write),
    .rsp_rdata(b_rsp_rdata)
  );

  // One request on instance A with rsp_ready high; returns edges from accept to rsp_valid (-1 on timeout).
  task automatic xact(input logic wr, input logic [63:0] addr, input logic [3:0] id,
                      input logic [255:0] wd, input logic [31:0] wm,
                      output int lat, output logic [3:0] rid, output logic rwr, output logic [255:0] rdat);
    int guard;
    req_write = wr; req_addr = addr; req_id = id; req_wdata = wd; req_wmask = wm; req_valid = 1'b1;
    guard = 0;
    while (!req_ready && guard < 20) begin @(posedge clk); #1; guard++; end
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 0;
    while (!rsp_valid && lat < 20) begin @(posedge clk); #1; lat++; end
    if (!rsp_valid) lat = -1;
    rid = rsp_id; rwr = rsp_write; rdat = rsp_rdata;
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL reset_req_ready: got %b want 0", req_ready); end
    n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid); end
    n_checks++; if (rsp_id !== 4'd0) begin n_fail++; $display("FAIL reset_rsp_id: got %h want 0", rsp_id); end
    n_checks++; if (rsp_write !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_write: got %b want 0", rsp_write); end
    n_checks++; if (rsp_rdata !== 256'd0) begin n_fail++; $display("FAIL reset_rsp_rdata: got %h want 0", rsp_rdata); end
    rst_n = 1'b1;
    @(posedge clk); #1;
    n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL post_reset_ready: got %b want 1", req_ready); end
    n_checks++; if (b_req_ready !== 1'b1) begin n_fail++; $display("FAIL post_reset_ready_b: got %b want 1", b_req_ready); end
  endtask

  task automatic test_write_read();
    int lat; logic [3:0] rid; logic rwr; logic [255:0] rdat;
    rsp_ready = 1'b1;
    xact(1'b1, 64'h40, 4'd1, WD_FIRST, 32'hFFFF_FFFF, lat, rid, rwr, rdat);
    n_checks++; if (lat != 4) begin n_fail++; $display("FAIL wr_latency: got %0d want 4", lat); end
    n_checks++; if (rid !== 4'd1) begin n_fail++; $display("FAIL wr_id: got %h want 1", rid); end
    n_checks++; if (rwr !== 1'b1) begin n_fail++; $display("FAIL wr_flag: got %b want 1", rwr); end
    n_checks++; if (rdat !== 256'd0) begin n_fail++; $display("FAIL wr_rdata: got %h want 0", rdat); end
    xact(1'b0, 64'h40, 4'd2, 256'd0, 32'd0, lat, rid, rwr, rdat);
    n_checks++; if (lat != 4) begin n_fail++; $display("FAIL rd_latency: got %0d want 4", lat); end
    n_checks++; if (rid !== 4'd2) begin n_fail++; $display("FAIL rd_id: got %h want 2", rid); end
    n_checks++; if (rwr !== 1'b0) begin n_fail++; $display("FAIL rd_flag: got %b want 0", rwr); end
    n_checks++; if (rdat !== WD_FIRST) begin n_fail++; $display("FAIL rd_data: got %h want %h", rdat, WD_FIRST); end
  endtask

  task automatic test_partial_mask();
    int lat; logic [3:0] rid; logic rwr; logic [255:0] rdat;
    xact(1'b1, 64'h80, 4'd3, WD_PRE, 32'hFFFF_FFFF, lat, rid, rwr, rdat);
    xact(1'b1, 64'h80, 4'd4, WD_PART, 32'h0000_010F, lat, rid, rwr, rdat);
    n_checks++; if (rid !== 4'd4) begin n_fail++; $display("FAIL part_wr_id: got %h want 4", rid); end
    xact(1'b0, 64'h80, 4'd5, 256'd0, 32'd0, lat, rid, rwr, rdat);
    n_checks++; if (rdat[63:0] !== 64'h1111_2222_CCCC_DDDD) begin n_fail++; $display("FAIL part_lane0: got %h want 1111_2222_cccc_dddd", rdat[63:0]); end
    n_checks++; if (rdat !== EXP_80) begin n_fail++; $display("FAIL part_all_lanes: got %h want %h", rdat, EXP_80); end
    xact(1'b1, 64'h80, 4'd6, WD_PART, 32'h0, lat, rid, rwr, rdat);
    xact(1'b0, 64'h80, 4'd7, 256'd0, 32'd0, lat, rid, rwr, rdat);
    n_checks++; if (rdat !== EXP_80) begin n_fail++; $display("FAIL zero_mask_untouched: got %h want %h", rdat, EXP_80); end
  endtask

  task automatic test_alignment();
    int lat; logic [3:0] rid; logic rwr; logic [255:0] rdat;
    xact(1'b1, 64'h47, 4'd6, WD_ALIGN, 32'hFFFF_FFFF, lat, rid, rwr, rdat);
    xact(1'b0, 64'h40, 4'd7, 256'd0, 32'd0, lat, rid, rwr, rdat);
    n_checks++; if (rdat !== WD_ALIGN) begin n_fail++; $display("FAIL align_0x40: got %h want %h", rdat, WD_ALIGN); end
    xact(1'b0, 64'h5F, 4'd8, 256'd0, 32'd0, lat, rid, rwr, rdat);
    n_checks++; if (rdat !== WD_ALIGN) begin n_fail++; $display("FAIL align_0x5f: got %h want %h", rdat, WD_ALIGN); end
    n_checks++; if (rid !== 4'd8) begin n_fail++; $display("FAIL align_id: got %h want 8", rid); end
  endtask

  task automatic test_backpressure();
    int n_acc, n_rsp, cycles;
    logic acc, hs;
    logic [3:0]   got_id [6];
    logic [255:0] got_dat [6];
    logic [255:0] held, want;
    @(posedge clk); #1;
    rsp_ready = 1'b0; n_acc = 0;
    req_write = 1'b0; req_wmask = 32'd0; req_wdata = 256'd0;
    req_id = 4'd0; req_addr = 64'h40; req_valid = 1'b1;
    for (int c = 0; c < 10; c++) begin
      acc = req_valid && req_ready;
      @(posedge clk); #1;
      if (acc) begin
        n_acc++;
        req_id = 4'(n_acc); req_addr = (n_acc % 2 == 1) ? 64'h80 : 64'h40;
      end
    end
    n_checks++; if (n_acc != 4) begin n_fail++; $display("FAIL bp_accepted: got %0d want 4", n_acc); end
    n_checks++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL bp_ready_low: got %b want 0", req_ready); end
    n_checks++; if (rsp_id !== 4'd0 || rsp_valid !== 1'b1) begin n_fail++; $display("FAIL bp_head: got valid %b id %h want 1/0", rsp_valid, rsp_id); end
    held = rsp_rdata;
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if (rsp_rdata !== WD_ALIGN || held !== WD_ALIGN) begin n_fail++; $display("FAIL bp_stable_data: got %h then %h want %h", held, rsp_rdata, WD_ALIGN); end
    n_checks++; if (rsp_id !== 4'd0) begin n_fail++; $display("FAIL bp_stable_id: got %h want 0", rsp_id); end
    rsp_ready = 1'b1;
    #1;
    n_checks++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL bp_no_comb_ready: got %b want 0", req_ready); end
    n_rsp = 0; cycles = 0;
    while (n_rsp < 6 && cycles < 40) begin
      hs = rsp_valid && rsp_ready;
      if (hs) begin got_id[n_rsp] = rsp_id; got_dat[n_rsp] = rsp_rdata; n_rsp++; end
      acc = req_valid && req_ready;
      @(posedge clk); #1; cycles++;
      if (acc) begin
        n_acc++;
        if (n_acc == 6) req_valid = 1'b0;
        else begin req_id = 4'(n_acc); req_addr = (n_acc % 2 == 1) ? 64'h80 : 64'h40; end
      end
      if (cycles == 1) begin
        n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL bp_ready_next_edge: got %b want 1", req_ready); end
      end
    end
    n_checks++; if (n_acc != 6) begin n_fail++; $display("FAIL bp_total_accepted: got %0d want 6", n_acc); end
    for (int i = 0; i < 6; i++) begin
      want = (i % 2 == 1) ? EXP_80 : WD_ALIGN;
      n_checks++; if (got_id[i] !== 4'(i)) begin n_fail++; $display("FAIL bp_order[%0d]: got %h want %h", i, got_id[i], 4'(i)); end
      n_checks++; if (got_dat[i] !== want) begin n_fail++; $display("FAIL bp_data[%0d]: got %h want %h", i, got_dat[i], want); end
    end
    req_valid = 1'b0;
  endtask

  task automatic test_reset_midflight();
    int stale, lat; logic [3:0] rid; logic rwr; logic [255:0] rdat;
    @(posedge clk); #1;
    rsp_ready = 1'b1; req_write = 1'b0; req_addr = 64'h40; req_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin req_id = 4'(8 + i); @(posedge clk); #1; end
    req_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL mid_rst_valid: got %b want 0", rsp_valid); end
    n_checks++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL mid_rst_ready: got %b want 0", req_ready); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL mid_rst_ready_after: got %b want 1", req_ready); end
    stale = rsp_valid ? 1 : 0;
    for (int c = 0; c < 10; c++) begin @(posedge clk); #1; if (rsp_valid) stale++; end
    n_checks++; if (stale != 0) begin n_fail++; $display("FAIL mid_rst_stale: got %0d stale cycles want 0", stale); end
    xact(1'b0, 64'h40, 4'd12, 256'd0, 32'd0, lat, rid, rwr, rdat);
    n_checks++; if (rid !== 4'd12 || rdat !== WD_ALIGN) begin n_fail++; $display("FAIL mid_rst_reread: got id %h data %h want c %h", rid, rdat, WD_ALIGN); end
  endtask

  task automatic test_throughput();
    int acc_edge [16];
    int rsp_edge [16];
    logic [3:0] rid [16];
    int n_acc, n_rsp, data_bad, order_bad;
    logic acc;
    n_acc = 0; n_rsp = 0; data_bad = 0; order_bad = 0;
    b_rsp_ready = 1'b1; b_req_write = 1'b0; b_req_addr = 64'h80; b_req_id = 4'd0; b_req_valid = 1'b1;
    for (int c = 0; c < 40 && n_rsp < 16; c++) begin
      if (b_rsp_valid && b_rsp_ready) begin
        rsp_edge[n_rsp] = cyc; rid[n_rsp] = b_rsp_id;
        if (b_rsp_rdata !== EXP_80) data_bad++;
        n_rsp++;
      end
      acc = b_req_valid && b_req_ready;
      @(posedge clk); #1;
      if (acc) begin
        acc_edge[n_acc] = cyc; n_acc++;
        if (n_acc == 16) b_req_valid = 1'b0; else b_req_id = 4'(n_acc);
      end
    end
    b_req_valid = 1'b0;
    for (int i = 0; i < 16; i++) if (rid[i] !== 4'(i)) order_bad++;
    n_checks++; if (n_acc != 16) begin n_fail++; $display("FAIL tp_accepted: got %0d want 16", n_acc); end
    n_checks++; if (acc_edge[15] - acc_edge[0] != 15) begin n_fail++; $display("FAIL tp_accept_span: got %0d want 15", acc_edge[15] - acc_edge[0]); end
    n_checks++; if (n_rsp != 16) begin n_fail++; $display("FAIL tp_responses: got %0d want 16", n_rsp); end
    n_checks++; if (rsp_edge[0] != acc_edge[0] + 4) begin n_fail++; $display("FAIL tp_first_latency: got %0d want 4", rsp_edge[0] - acc_edge[0]); end
    n_checks++; if (rsp_edge[15] - rsp_edge[0] != 15) begin n_fail++; $display("FAIL tp_rsp_span: got %0d want 15", rsp_edge[15] - rsp_edge[0]); end
    n_checks++; if (order_bad != 0) begin n_fail++; $display("FAIL tp_order: got %0d misordered want 0", order_bad); end
    n_checks++; if (data_bad != 0) begin n_fail++; $display("FAIL tp_data: got %0d bad beats want 0", data_bad); end
  endtask

  initial begin
    req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_id = '0; req_wdata = '0; req_wmask = '0;
    rsp_ready = 1'b1;
    b_req_valid = 1'b0; b_req_write = 1'b0; b_req_addr = '0; b_req_id = '0; b_req_wdata = '0;
    b_req_wmask = '0; b_rsp_ready = 1'b1;
    test_reset();
    test_write_read();
    test_partial_mask();
    test_alignment();
    test_backpressure();
    test_reset_midflight();
    test_throughput();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, got timeout want finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/mem_dpi_port.md
# mem_dpi_port

Parametrised, synthesis-style front end to the C++ DPI backing memory used by the NHDSU simulation benches. It accepts one read or write request per cycle on a valid/ready channel and splits wide beats into 64-bit DPI lanes. Writes are byte-masked read-modify-write. Reads return after a fixed, configurable latency through a backpressured, in-order response channel with bounded outstanding requests. It replaces ad-hoc direct `mem_read_helper`/`mem_write_helper` calls in benches with a cycle-accurate memory agent.

## Interface
Parameters:
- `ADDR_W`, 64: byte-address width.
- `DATA_W`, 256: beat width; a multiple of 64; `LANES = DATA_W/64`.
- `ID_W`, 4: request tag width.
- `LAT`, 4: read/write response latency in cycles, ≥1.
- `RSP_DEPTH`, 4: maximum outstanding requests, ≥1.

Ports:
- `clk` input 1: single clock, all logic on its rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `req_valid` input 1: request present.
- `req_ready` output 1: request accepted when high together with `req_valid`.
- `req_write` input 1: 1 = write, 0 = read.
- `req_addr` input ADDR_W: byte address; low log2(DATA_W/8) bits ignored (beat-aligned).
- `req_id` input ID_W: tag, echoed on the response.
- `req_wdata` input DATA_W: write data.
- `req_wmask` input DATA_W/8: byte enables, bit i covers `req_wdata[8i+7:8i]`.
- `rsp_valid` output 1: response present.
- `rsp_ready` input 1: consumer accepts the response.
- `rsp_id` output ID_W: tag of the completed request.
- `rsp_write` output 1: completed request was a write.
- `rsp_rdata` output DATA_W: read data; 0 for writes.

## Operation
- Accept = `req_valid && req_ready`. `req_ready = (credit != 0)`, driven from a register only, with no path from `req_valid`.
- Credit counter (0..RSP_DEPTH, reset RSP_DEPTH):
  - −1 on accept.
  - +1 on response handshake (`rsp_valid && rsp_ready`).
  - Both in the same cycle: unchanged.
- Write on the accept edge, for each lane k with any mask bit set:
  - `old = mem_read_helper(1, base+8k)`.
  - `new = (old & ~M) | (wdata_k & M)`, where M is the byte mask expanded to bits.
  - `mem_write_helper(1, base+8k, new)`.
  - Lanes with an all-zero mask are not touched.
- Read on the accept edge: all LANES lanes are sampled from DPI and captured. Later writes do not alter data already captured.
- Captured entry {id, write, rdata} enters a LAT-stage shift pipeline (valid bit per stage). It then pushes into the response FIFO, depth RSP_DEPTH.
- The FIFO cannot overflow: credit guarantees pipeline + FIFO occupancy ≤ RSP_DEPTH.
- Responses are strictly in acceptance order. The outputs present the FIFO head, and an unaccepted head holds stable.
- Backing memory contents are owned by C++ and are never cleared by reset.

## Timing
- Request accepted at edge t → `rsp_valid` high from edge t+LAT, provided all older responses have drained.
- With `rsp_ready` held at 1, sustained throughput is one request per cycle once RSP_DEPTH ≥ LAT+1. Otherwise it is capped at RSP_DEPTH per LAT+1 cycles.
- Read after write: a read accepted at any edge after the write's accept edge returns the new data.
- Reset values: `req_ready` 0 while `rst_n` low, and 1 in the first cycle after deassertion. `rsp_valid` 0, `rsp_id` 0, `rsp_write` 0, `rsp_rdata` 0.
- Reset asserted mid-operation:
  - All pipeline valid bits, FIFO contents and pending responses are discarded.
  - Credit returns to RSP_DEPTH.
  - Writes already performed stay in memory.
- Full: credit = 0 → `req_ready` 0. A response handshake in that cycle raises `req_ready` at the next edge, not combinationally.
- Empty FIFO: a pipeline exit in a cycle with `rsp_ready` high is visible on `rsp_valid` from the next edge; there is no bypass.

## Structure
- Package `mem_dpi_pkg`:
  - DPI imports `mem_read_helper`/`mem_write_helper`.
  - `LANE_W = 64`.
  - Function `lane_merge(old, data, mask8)`.
  - Packed struct `mem_rsp_t` {id, write, rdata}, parameterised via the module.
- One sub-module, `mem_rsp_fifo`: synchronous FIFO with pointers and count, async active-low reset, parameters WIDTH/DEPTH.

## Test plan
- Write then read: write addr 0x40, wdata lane0=0xDEA, mask all-ones, id 1 → response id 1, write=1 after 4 cycles. Then read 0x40, id 2 → rdata lane0=0xDEA, other lanes as written, 4 cycles after accept.
- Partial mask: preload lane0=0x1111_2222_3333_4444, write 0xAAAA_BBBB_CCCC_DDDD with mask 0x0F → read returns 0x1111_2222_CCCC_DDDD. Lanes with zero mask are unchanged.
- Backpressure: `rsp_ready`=0, issue 6 reads with RSP_DEPTH=4 → exactly 4 accepted and `req_ready` falls. Release `rsp_ready` → ids return 0,1,2,3 in order with stable data while stalled, then the remaining two are accepted.
- Throughput: LAT=4, RSP_DEPTH=8, `rsp_ready`=1, 16 back-to-back reads → 16 responses on consecutive cycles, first at accept+4.
- Reset mid-flight: 3 reads outstanding, pulse `rst_n` low for one cycle → `rsp_valid` 0, no stale responses afterwards, `req_ready` 1. A subsequent read of a previously written address returns the written data.
- Alignment: write to 0x47 → identical effect to 0x40 for DATA_W=256.
